// File: rtl/ov5640_pkg.sv
// ov5640_pkg: shared types, constants and helpers for the OV5640 init sequencer
package ov5640_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_FETCH,
        S_FETCH_WAIT,
        S_LATCH,
        S_ISSUE,
        S_RETRY_GAP,
        S_CHECK,
        S_RST_WAIT,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [15:0] SOFT_RST_REG = 16'h3008;

    function automatic int us_to_cycles(input int us, input int clk_hz);
        return us * (clk_hz / 1_000_000);
    endfunction

endpackage

// File: rtl/init_delay_timer.sv
// init_delay_timer: loadable down-counter that flags expiry when it reaches zero
module init_delay_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    // load takes priority; otherwise count down and stick at zero
    always_comb begin
        cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = cnt_q == '0;

endmodule

// File: rtl/ov5640_init_seq.sv
// ov5640_init_seq: walks the init ROM and issues one SCCB write per entry, with power-up and soft-reset waits
module ov5640_init_seq
    import ov5640_pkg::*;
#(
    parameter int DATA_WIDTH        = 24,
    parameter int ADDR_WIDTH        = 8,
    parameter int TABLE_LEN         = 88,
    parameter int CLK_FREQ_HZ       = 50_000_000,
    parameter int POWERUP_DELAY_US  = 20000,
    parameter int SOFT_RST_DELAY_US = 5000,
    parameter int MAX_RETRY         = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_nack,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_error
);

    localparam int PWR_CYC = us_to_cycles(POWERUP_DELAY_US, CLK_FREQ_HZ);
    localparam int RST_CYC = us_to_cycles(SOFT_RST_DELAY_US, CLK_FREQ_HZ);
    localparam int MAX_CYC = PWR_CYC > RST_CYC ? PWR_CYC : RST_CYC;
    localparam int CNT_W   = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
    localparam int RTY_W   = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

    // a wait of N cycles loads N-1 so the wait state lasts exactly N cycles
    localparam logic [CNT_W-1:0]      PWR_LOAD = CNT_W'(PWR_CYC > 0 ? PWR_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]      RST_LOAD = CNT_W'(RST_CYC > 0 ? RST_CYC - 1 : 0);
    localparam logic [RTY_W-1:0]      RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(TABLE_LEN - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [RTY_W-1:0]        retry_q, retry_d;
    logic [15:0]             addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic                    wr_req_q, wr_req_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    tmr_load, tmr_expired;
    logic [CNT_W-1:0]        tmr_val;
    logic                    last, soft_rst;

    assign last     = idx_q == LAST;
    assign soft_rst = addr_q == SOFT_RST_REG && data_q[7];

    init_delay_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE:       state_d = S_PWR_WAIT;
            S_PWR_WAIT: begin
                if (tmr_expired) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = S_LATCH;
            S_LATCH: begin
                addr_d  = rom_q[DATA_WIDTH-1 -: 16];
                data_d  = rom_q[7:0];
                retry_d = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (wr_done) begin
                    if (!wr_nack) begin
                        state_d = S_CHECK;
                    end else if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_RETRY_GAP;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_RETRY_GAP:  state_d = S_ISSUE;
            S_CHECK: begin
                if (soft_rst) begin
                    state_d = S_RST_WAIT;
                end else begin
                    state_d = last ? S_DONE : S_FETCH;
                    idx_d   = last ? idx_q : idx_q + 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (tmr_expired) begin
                    state_d = last ? S_DONE : S_FETCH;
                    idx_d   = last ? idx_q : idx_q + 1'b1;
                end
            end
            S_DONE, S_ERROR: state_d = start ? S_PWR_WAIT : state_q;
            default:      state_d = S_IDLE;
        endcase
        wr_req_d = state_d == S_ISSUE;
        busy_d   = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
        done_d   = state_d == S_DONE;
        err_d    = state_d == S_ERROR;
        tmr_load = state_d != state_q && (state_d == S_PWR_WAIT || state_d == S_RST_WAIT);
        tmr_val  = state_d == S_RST_WAIT ? RST_LOAD : PWR_LOAD;
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            retry_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_req_q <= wr_req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rom_addr    = idx_q;
    assign wr_req      = wr_req_q;
    assign wr_reg_addr = addr_q;
    assign wr_data     = data_q;
    assign busy        = busy_q;
    assign init_done   = done_q;
    assign init_error  = err_q;

endmodule
